// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared definitions for the multiplexed seven-segment driver.
//   - segment bit indices within the {g,f,e,d,c,b,a} bus
//   - 16-entry hex-to-segment table (active-high, bit 0 = segment a)
//   - scan FSM state enum
//   - cnt_width(): register width needed to count 0..n-1
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Index 15 first: F, E, d, C, b, A, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_mux_if.sv
// seven_seg_mux_if: display-value input and display-pin output bundle.
//   master: producer of enable/load/value/dp_in/minus_in, consumer of pins
//   slave : the driver (seven_seg_mux)
// Signals: enable, load, value[4N], dp_in[N], minus_in (to driver);
//          seven_seg_sel[N], seg[7], seven_seg_dp, seven_seg_minus,
//          frame_done (from driver).
interface seven_seg_mux_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    minus_in;
  logic [NUM_DIGITS-1:0]   seven_seg_sel;
  logic [6:0]              seg;
  logic                    seven_seg_dp;
  logic                    seven_seg_minus;
  logic                    frame_done;

  modport master (
    output enable, load, value, dp_in, minus_in,
    input  seven_seg_sel, seg, seven_seg_dp, seven_seg_minus, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in, minus_in,
    output seven_seg_sel, seg, seven_seg_dp, seven_seg_minus, frame_done
  );
endinterface

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational hex nibble to segment pattern, active-high.
// Ports: i_nibble (hex digit), i_blank (force all segments off),
//        o_seg {g,f,e,d,c,b,a}.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);
  logic [6:0] w_pat;

  assign w_pat = HEX_SEG[i_nibble];
  assign o_seg = i_blank ? 7'h00
                         : {w_pat[SEG_G], w_pat[SEG_F], w_pat[SEG_E], w_pat[SEG_D],
                            w_pat[SEG_C], w_pat[SEG_B], w_pat[SEG_A]};
endmodule

// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed N-digit seven-segment driver.
// Each digit slot is DIV = CLK_HZ/SCAN_HZ cycles: BLANK_CYCLES with all
// selects off (anti-ghosting), then the digit's select driven. The shown
// value is double-buffered: loads land in a pending register and reach the
// active register only at frame boundaries.
// Ports: clkin_50 (clock), cpu_reset (sync, active-high),
//        bus (seven_seg_mux_if.slave: enable/load/value/dp_in/minus_in in,
//        seven_seg_sel/seg/seven_seg_dp/seven_seg_minus/frame_done out).
// Build option: SEVEN_SEG_LZB_EN enables leading-zero blanking.
//
// state | meaning
// IDLE  | scanning off, all outputs inactive
// BLANK | start of slot, selects off, segments pre-driven for current digit
// DRIVE | current digit's select asserted until slot end
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input logic              clkin_50,
  input logic              cpu_reset,
  seven_seg_mux_if.slave   bus
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = cnt_width(DIV);
  localparam int DW  = cnt_width(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SLOT_END  = CW'(DIV - 1);
  localparam logic [DW-1:0] DIG_LAST      = DW'(NUM_DIGITS - 1);

  // XOR masks: an active-high pattern XOR the mask gives the pin level
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [DW-1:0]           r_digit, w_digit_nxt;
  logic                    w_wrap, w_boundary;

  logic [4*NUM_DIGITS-1:0] r_pend_val, r_act_val, w_act_val_nxt;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp, w_act_dp_nxt;
  logic                    r_pend_minus, r_act_minus, w_act_minus_nxt;

  logic [3:0]              w_nib;
  logic                    w_dp_bit, w_blank;
  logic [NUM_DIGITS-1:0]   w_onehot, w_blank_mask;
  logic [6:0]              w_seg_raw, w_seg_on;
  logic [NUM_DIGITS-1:0]   w_sel_on;
  logic                    w_dp_on, w_minus_on;

  logic [NUM_DIGITS-1:0]   r_sel;
  logic [6:0]              r_seg;
  logic                    r_dp, r_minus, r_frame_done;

  always_ff @(posedge clkin_50) begin
    if (cpu_reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_digit      <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_minus <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_minus  <= 1'b0;
      r_sel        <= SEL_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= SEG_ACTIVE_LOW;
      r_minus      <= SEG_ACTIVE_LOW;
      r_frame_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_digit     <= w_digit_nxt;
      if (bus.load) begin
        r_pend_val   <= bus.value;
        r_pend_dp    <= bus.dp_in;
        r_pend_minus <= bus.minus_in;
      end
      r_act_val    <= w_act_val_nxt;
      r_act_dp     <= w_act_dp_nxt;
      r_act_minus  <= w_act_minus_nxt;
      r_sel        <= w_sel_on ^ SEL_OFF;
      r_seg        <= w_seg_on ^ SEG_OFF;
      r_dp         <= w_dp_on ^ SEG_ACTIVE_LOW;
      r_minus      <= w_minus_on ^ SEG_ACTIVE_LOW;
      r_frame_done <= w_wrap;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_digit_nxt = r_digit;
    w_wrap      = 1'b0;
    w_boundary  = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_digit_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_digit_nxt = '0;
          w_boundary  = 1'b1;
        end
        BLANK: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == CNT_BLANK_END) w_state_nxt = DRIVE;
        end
        DRIVE: begin
          if (r_cnt == CNT_SLOT_END) begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
            if (r_digit == DIG_LAST) begin
              w_digit_nxt = '0;
              w_wrap      = 1'b1;
              w_boundary  = 1'b1;
            end else begin
              w_digit_nxt = r_digit + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A load sampled on the boundary edge bypasses the pending register
  always_comb begin
    w_act_val_nxt   = r_act_val;
    w_act_dp_nxt    = r_act_dp;
    w_act_minus_nxt = r_act_minus;
    if (w_boundary) begin
      w_act_val_nxt   = bus.load ? bus.value    : r_pend_val;
      w_act_dp_nxt    = bus.load ? bus.dp_in    : r_pend_dp;
      w_act_minus_nxt = bus.load ? bus.minus_in : r_pend_minus;
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic w_lead;

  // Walk from the most significant digit; digit 0 always stays visible
  always_comb begin
    w_lead       = 1'b1;
    w_blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (w_lead && (w_act_val_nxt[4*i +: 4] == 4'h0) && !w_act_dp_nxt[i])
        w_blank_mask[i] = 1'b1;
      else
        w_lead = 1'b0;
    end
  end
`else
  assign w_blank_mask = '0;
`endif

  // Outputs are computed from next-cycle state so the registered pins line
  // up with the state they describe.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_blank  = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_digit_nxt == DW'(i)) begin
        w_nib       = w_act_val_nxt[4*i +: 4];
        w_dp_bit    = w_act_dp_nxt[i];
        w_blank     = w_blank_mask[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_decode u_decode (
    .i_nibble (w_nib),
    .i_blank  (w_blank),
    .o_seg    (w_seg_raw)
  );

  always_comb begin
    w_seg_on   = (w_state_nxt != IDLE) ? w_seg_raw : 7'h00;
    w_sel_on   = (w_state_nxt == DRIVE) ? w_onehot : '0;
    w_dp_on    = (w_state_nxt == DRIVE) && w_dp_bit;
    w_minus_on = (w_state_nxt != IDLE) && w_act_minus_nxt;
  end

  assign bus.seven_seg_sel   = r_sel;
  assign bus.seg             = r_seg;
  assign bus.seven_seg_dp    = r_dp;
  assign bus.seven_seg_minus = r_minus;
  assign bus.frame_done      = r_frame_done;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Bench for seven_seg_mux: NUM_DIGITS=4, DIV=10, BLANK_CYCLES=2, active-low pins.
// The stimulus process queues one expected record per select window; the
// monitor measures each window on the falling edge and checks it on close.
module tb_seven_seg_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_mux_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_mux #(
    .NUM_DIGITS     (4),
    .CLK_HZ         (1000),
    .SCAN_HZ        (100),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clkin_50  (clk),
    .cpu_reset (rst),
    .bus       (bus)
  );

  // Active-low patterns of the digits used below
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00, SA = 7'h08, SF = 7'h0E;
`ifdef SEVEN_SEG_LZB_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       minus;
    logic       fd;
    int         len;
    int         gap;
  } win_t;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n   = 0;
  int   stray_fd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push_win(input logic [3:0] sel, input logic [6:0] seg, input logic dp,
                          input logic minus, input logic fd, input int len, input int gap);
    win_t w;
    w.sel = sel; w.seg = seg; w.dp = dp; w.minus = minus; w.fd = fd; w.len = len; w.gap = gap;
    exp_q.push_back(w);
  endtask

  // gap0 = 0: blank gap before digit 0 not checked (first window after enable)
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpm, input logic minus,
                            input int gap0);
    push_win(4'hE, s0, ~dpm[0], ~minus, 1'b0, 8, gap0);
    push_win(4'hD, s1, ~dpm[1], ~minus, 1'b0, 8, 2);
    push_win(4'hB, s2, ~dpm[2], ~minus, 1'b0, 8, 2);
    push_win(4'h7, s3, ~dpm[3], ~minus, 1'b1, 8, 2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int e);
    while (edge_n < e) step();
  endtask

  // load sampled exactly at edge e
  task automatic load_at(input int e, input logic [15:0] v, input logic [3:0] dp, input logic mn);
    go_to(e - 1);
    bus.load = 1'b1; bus.value = v; bus.dp_in = dp; bus.minus_in = mn;
    go_to(e);
    bus.load = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sel"},   32'(bus.seven_seg_sel),   32'hF);
    chk({tag, "_seg"},   32'(bus.seg),             32'h7F);
    chk({tag, "_dp"},    32'(bus.seven_seg_dp),    32'h1);
    chk({tag, "_minus"}, 32'(bus.seven_seg_minus), 32'h1);
    chk({tag, "_fd"},    32'(bus.frame_done),      32'h0);
  endtask

  // Monitor
  logic [3:0] m_sel;
  logic [6:0] m_seg;
  logic       m_dp, m_minus, m_unstable;
  logic       in_win  = 1'b0;
  int         m_len   = 0;
  int         m_gap   = 0;
  int         gap_cnt = 0;
  win_t       m_exp;

  initial forever begin
    @(negedge clk);
    if (bus.seven_seg_sel != 4'hF) begin
      if (!in_win) begin
        in_win = 1'b1;
        m_sel = bus.seven_seg_sel; m_seg = bus.seg;
        m_dp = bus.seven_seg_dp; m_minus = bus.seven_seg_minus;
        m_len = 0; m_gap = gap_cnt; m_unstable = 1'b0;
      end else if (bus.seven_seg_sel != m_sel || bus.seg != m_seg ||
                   bus.seven_seg_dp != m_dp || bus.seven_seg_minus != m_minus) begin
        m_unstable = 1'b1;
      end
      m_len++;
      if (bus.frame_done) stray_fd++;
    end else if (in_win) begin
      in_win  = 1'b0;
      gap_cnt = 1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL win_unexpected: got window sel=0x%0h seg=0x%0h, expected none", m_sel, m_seg);
      end else begin
        m_exp = exp_q.pop_front();
        chk("win_sel",    32'(m_sel),             32'(m_exp.sel));
        chk("win_seg",    32'(m_seg),             32'(m_exp.seg));
        chk("win_dp",     32'(m_dp),              32'(m_exp.dp));
        chk("win_minus",  32'(m_minus),           32'(m_exp.minus));
        chk("win_len",    32'(m_len),             32'(m_exp.len));
        chk("win_stable", 32'(m_unstable),        32'h0);
        chk("win_end_fd", 32'(bus.frame_done),    32'(m_exp.fd));
        chk("win_end_dp", 32'(bus.seven_seg_dp),  32'h1);
        if (m_exp.gap != 0) chk("win_gap", 32'(m_gap), 32'(m_exp.gap));
      end
    end else begin
      gap_cnt++;
      if (bus.frame_done) stray_fd++;
    end
  end

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1; bus.load = 1'b1;
    bus.value = 16'h12AF; bus.dp_in = 4'b0000; bus.minus_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    push_frame(SF, SA, S2, S1, 4'b0000, 1'b0, 0);
    rst = 1'b0;

    // Enable sampled at edge 1 (also a boundary with load high)
    step();
    bus.load = 1'b0;
    chk("lat_e1_sel", 32'(bus.seven_seg_sel), 32'hF);
    chk("blank_seg",  32'(bus.seg),           32'(SF));
    step();
    chk("lat_e2_sel", 32'(bus.seven_seg_sel), 32'hF);
    step();
    chk("lat_e3_sel", 32'(bus.seven_seg_sel), 32'hE);
    push_frame(SF, SA, S2, S1, 4'b0000, 1'b0, 2);

    // Mid-frame loads only reach the next frame; last one wins
    load_at(50, 16'h1234, 4'b0000, 1'b0);
    load_at(70, 16'h5678, 4'b0000, 1'b0);
    push_frame(S8, S7, S6, S5, 4'b0000, 1'b0, 2);

    // Load on the boundary edge goes straight to the following frame
    push_frame(S5, S6, S7, S8, 4'b0000, 1'b0, 2);
    load_at(121, 16'h8765, 4'b0000, 1'b0);

    load_at(140, 16'h0040, 4'b0000, 1'b0);
    push_frame(S0, S4, LZ, LZ, 4'b0000, 1'b0, 2);
    load_at(180, 16'h0000, 4'b0000, 1'b0);
    push_frame(S0, LZ, LZ, LZ, 4'b0000, 1'b0, 2);
    load_at(220, 16'h0000, 4'b1000, 1'b0);
    push_frame(S0, S0, S0, S0, 4'b1000, 1'b0, 2);
    load_at(260, 16'h1234, 4'b0100, 1'b1);
    push_frame(S4, S3, S2, S1, 4'b0100, 1'b1, 2);

    // Blank cycle of digit 1: segments pre-driven, minus on, sel/dp off
    go_to(291);
    chk("blank_sel",   32'(bus.seven_seg_sel),   32'hF);
    chk("blank_seg3",  32'(bus.seg),             32'(S3));
    chk("blank_minus", 32'(bus.seven_seg_minus), 32'h0);
    chk("blank_dp",    32'(bus.seven_seg_dp),    32'h1);

    // Frame 8 abandoned three cycles into digit 2's select window
    push_win(4'hE, S4, 1'b1, 1'b0, 1'b0, 8, 2);
    push_win(4'hD, S3, 1'b1, 1'b0, 1'b0, 8, 2);
    push_win(4'hB, S2, 1'b0, 1'b0, 1'b0, 3, 2);
    go_to(345);
    bus.enable = 1'b0;
    go_to(346);
    chk_idle("disable");
    go_to(360);
    chk_idle("idle");

    push_frame(S4, S3, S2, S1, 4'b0100, 1'b1, 0);
    bus.enable = 1'b1;
    step();
    chk("reen_e1_sel",   32'(bus.seven_seg_sel),   32'hF);
    chk("reen_e1_minus", 32'(bus.seven_seg_minus), 32'h0);
    step();
    chk("reen_e2_sel",   32'(bus.seven_seg_sel),   32'hF);
    step();
    chk("reen_e3_sel",   32'(bus.seven_seg_sel),   32'hE);
    chk("reen_e3_seg",   32'(bus.seg),             32'(S4));

    go_to(403);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("stray_frame_done",  32'(stray_fd),     32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
